im_fetch_arbiter: RTL

Shares the single read port of the instruction ROM between the CPU fetch stage (IF) and a debug/monitor read port (DBG). It drives the ROM byte address, checks each address against the ROM window, and returns registered read data with a one-cycle latency. It sits between the IF stage / debug unit and the combinational instruction ROM, which has 32-bit byte address in and 32-bit word out.

---
 rtl/im_fetch_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/im_fetch_arbiter.sv
// Arbiter for the instruction ROM read port, shared by IF fetch and DBG reads, with a range check and one-cycle registered responses.
// Optional DBG anti-starvation counter: define IM_ARB_FAIR_EN.
module im_fetch_arbiter #(
    parameter logic [31:0] BASE         = 32'h0000_3000,
    parameter int unsigned DEPTH_WORDS  = 4096,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_ready,
    output logic        dbg_valid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data
);

    typedef enum logic {PORT_IF = 1'b0, PORT_DBG = 1'b1} port_e;

    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    logic        grant_if;
    logic        grant_dbg;
    logic        fault;
    logic        resp_pending;
    port_e       resp_port;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // The offset is only trusted once addr >= BASE, so a low address cannot wrap into range.
    function automatic logic addr_fault(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a < BASE) || (off >= SPAN) || (a[1:0] != 2'b00);
    endfunction

`ifdef IM_ARB_FAIR_EN
    logic [3:0] starve_cnt;
    logic       force_dbg;

    assign force_dbg = dbg_req && (starve_cnt == 4'(STARVE_LIMIT));
    assign grant_if  = !reset && if_req && !if_flush && !force_dbg;

    // Counts IF wins against a waiting DBG; a forced DBG win or an idle DBG restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!dbg_req || grant_dbg) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign grant_if = !reset && if_req && !if_flush;
`endif

    assign grant_dbg = !reset && dbg_req && !grant_if;
    assign if_ready  = grant_if;
    assign dbg_ready = grant_dbg;

    always_comb begin
        // NOTE: default first so every path assigns im_addr and no latch is inferred.
        im_addr = BASE;
        if (grant_if) begin
            im_addr = if_addr;
        end else if (grant_dbg) begin
            im_addr = dbg_addr;
        end
    end

    assign fault = addr_fault(im_addr);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            resp_pending <= 1'b0;
            resp_port    <= PORT_IF;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
        end else begin
            resp_pending <= grant_if || grant_dbg;
            if (grant_if || grant_dbg) begin
                resp_port  <= grant_dbg ? PORT_DBG : PORT_IF;
                resp_rdata <= fault ? 32'h0 : im_data;
                resp_err   <= fault;
            end
        end
    end

    // A flush in the response cycle drops a pending IF response outright.
    assign if_valid  = !reset && resp_pending && (resp_port == PORT_IF) && !if_flush;
    assign dbg_valid = !reset && resp_pending && (resp_port == PORT_DBG);
    assign if_rdata  = if_valid  ? resp_rdata : 32'h0;
    assign if_err    = if_valid  && resp_err;
    assign dbg_rdata = dbg_valid ? resp_rdata : 32'h0;
    assign dbg_err   = dbg_valid && resp_err;

endmodule
